// File: rtl/regfile_dump_ctrl.sv
// Sweeps R0..R(NUM_REGS-1) through the register file SR2 read port and streams each value out.
// Optional trailing XOR checksum word when DUMP_CHECKSUM_EN is defined.
module regfile_dump_ctrl #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  sr_sel,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_csum
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
`ifdef DUMP_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic                out_last_q, out_last_d;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                out_csum_q, out_csum_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                data_d  = rd_data;
`ifdef DUMP_CHECKSUM_EN
                csum_d  = csum_q ^ rd_data;
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (out_ready) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort overrides any handshake in the same cycle
        if (abort && state_q != S_IDLE) state_d = S_IDLE;

        // outputs are registered, so decode them from the next state
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        out_valid_d = (state_d == S_SEND);
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        if (state_d == S_SEND) begin
            out_data_d = data_d;
            out_idx_d  = idx_d;
`ifndef DUMP_CHECKSUM_EN
            out_last_d = (idx_d == LAST_IDX);
`endif
        end
`ifdef DUMP_CHECKSUM_EN
        out_csum_d = 1'b0;
        if (state_d == S_CSUM) begin
            out_valid_d = 1'b1;
            out_data_d  = csum_d;
            out_idx_d   = LAST_IDX;
            out_last_d  = 1'b1;
            out_csum_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q      <= '0;
            out_csum_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
            out_csum_q  <= out_csum_d;
`endif
        end
    end

    assign sr_sel    = (state_q == S_IDLE) ? '0 : idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
`ifdef DUMP_CHECKSUM_EN
    assign out_csum  = out_csum_q;
`else
    assign out_csum  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: a register file model feeds rd_data,
// expected words are queued per sweep and checked at each stream handshake.
module tb_regfile_dump_ctrl;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int IW = 3;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [DW-1:0] rd_data;
    logic [IW-1:0] sr_sel;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_csum;

    logic [DW-1:0] regs [NR];
    assign rd_data = regs[sr_sel];

    regfile_dump_ctrl #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_data(rd_data), .sr_sel(sr_sel), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_csum(out_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [20:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] base(input int i);
        return 16'(16'h1111 * (i + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stream monitor: scoreboard pop on handshake, stability check while stalled
    bit          hold_chk = 1'b0;
    logic [20:0] hold_word;
    always @(negedge clk) begin
        logic [20:0] w;
        logic [31:0] e;
        w = {out_csum, out_last, out_idx, out_data};
        if (hold_chk) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_word", {11'b0, w}, {11'b0, hold_word});
        end
        hold_chk  = out_valid && !out_ready && !reset && !abort;
        hold_word = w;
        if (done) done_cnt++;
        if (out_valid && out_ready && !reset) begin
            e = (exp_q.size() > 0) ? {11'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            check("word", {11'b0, w}, e);
            check("sr_sel", {29'b0, sr_sel}, {29'b0, e[18:16]});
        end
    end

    task automatic sweep(input int mode, input bit spam, input bit snap,
                         input int abort_at, input int reset_at, output int done_at);
        logic [DW-1:0] v;
        logic [DW-1:0] x;
        bit snapped;
        int n;
        x = '0;
        snapped = 1'b0;
        done_at = -1;
        for (int i = 0; i < NR; i++) begin
            if (abort_at >= 0 && i > abort_at) break;
            if (reset_at >= 0 && i >= reset_at) break;
            v = (snap && i == 6) ? 16'hCAFE : base(i);
            x ^= v;
            exp_q.push_back({1'b0, (i == NR - 1) && !CSUM_EN, 3'(i), v});
        end
        if (CSUM_EN && abort_at < 0 && reset_at < 0)
            exp_q.push_back({2'b11, 3'(NR - 1), x});

        start = 1'b1;
        out_ready = (mode == 0);
        tick();
        start = 1'b0;
        n = 1;
        for (int k = 0; k < 300; k++) begin
            if (done && done_at < 0) done_at = n;
            if (!busy) break;
            out_ready = (mode == 0) || (k % 3 == 2);
            start = spam && (k % 4 == 1);
            if (snap && !snapped && out_valid && out_idx == 3'd5) begin
                regs[5] = 16'hBEEF;
                regs[6] = 16'hCAFE;
                snapped = 1'b1;
            end
            if (abort_at >= 0 && out_valid && !out_csum && int'(out_idx) == abort_at) begin
                abort = 1'b1;
                out_ready = 1'b1;
            end
            if (reset_at >= 0 && out_valid && !out_csum && int'(out_idx) == reset_at) begin
                reset = 1'b1;
                out_ready = 1'b0;
            end
            tick();
            n++;
            if (abort) begin
                abort = 1'b0;
                check("abort_idle", {29'b0, busy, out_valid, done}, 32'd0);
            end
            if (reset) begin
                reset = 1'b0;
                check("rst_mid_outs", {busy, done, out_valid, out_last, out_csum, sr_sel, out_idx, out_data}, '0);
            end
        end
        start = 1'b0;
        check("sweep_end_busy", {31'b0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int d;
        int dc;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NR; i++) regs[i] = base(i);
        repeat (3) tick();
        check("reset_outs", {busy, done, out_valid, out_last, out_csum, sr_sel, out_idx, out_data}, '0);
        reset = 1'b0;
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);

        // start with abort in IDLE must not launch a sweep
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("start_abort_idle", {30'b0, busy, out_valid}, 32'd0);

        // basic sweep, ready held high: first valid two cycles after start
        dc = done_cnt;
        start = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, !CSUM_EN, 3'd7, 16'h8888});
        exp_q.delete();
        sweep(0, 1'b0, 1'b0, -1, -1, d);
        check("done_timing", d, CSUM_EN ? 32'd18 : 32'd17);
        check("done_count_basic", done_cnt - dc, 32'd1);
        check("done_low_after", {31'b0, done}, 32'd0);

        // first-valid latency measured directly
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        check("t1_fetch", {30'b0, busy, out_valid}, 32'd2);
        tick();
        check("t2_valid", {11'b0, out_valid, out_idx, out_data}, {11'b0, 1'b1, 3'd0, 16'h1111});
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // backpressure with start pulses while busy
        dc = done_cnt;
        sweep(1, 1'b1, 1'b0, -1, -1, d);
        check("done_count_bp", done_cnt - dc, 32'd1);

        // snapshot: late write to R5 ignored, early write to R6 seen
        sweep(0, 1'b0, 1'b1, -1, -1, d);
        for (int i = 0; i < NR; i++) regs[i] = base(i);

        // abort during SEND of R3, then a clean restart from R0
        dc = done_cnt;
        sweep(0, 1'b0, 1'b0, 3, -1, d);
        check("abort_no_done", done_cnt - dc, 32'd0);
        sweep(0, 1'b0, 1'b0, -1, -1, d);
        check("restart_done_timing", d, CSUM_EN ? 32'd18 : 32'd17);

        // reset during SEND of R2
        dc = done_cnt;
        sweep(0, 1'b0, 1'b0, -1, 2, d);
        check("reset_no_done", done_cnt - dc, 32'd0);
        dc = done_cnt;
        sweep(1, 1'b0, 1'b0, -1, -1, d);
        check("post_reset_done", done_cnt - dc, 32'd1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Sequential read-out controller for the 8×16 general-purpose register file. It sweeps R0..R7 through the register file's combinational SR2 read port and emits each value as a word on a valid/ready stream, for debug display or host upload. It is the read-side counterpart to the bus-driven write path (LDREG/DR). Inside the datapath, it shares the SR2 select only while the datapath is halted.

## Interface
Parameters:
- DATA_W, 16, register width
- NUM_REGS, 8, registers swept (R0..NUM_REGS-1)
- IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_REGS

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a sweep; sampled in IDLE only
- abort  in  1  cancel a sweep in progress
- rd_data  in  DATA_W  register file SR2_out, combinational on sr_sel
- sr_sel  out  IDX_W  register index driven to register file SR2 select
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the final word is accepted
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts the word when out_valid && out_ready
- out_data  out  DATA_W  register value (or checksum)
- out_idx  out  IDX_W  register index of out_data
- out_last  out  1  marks the final word of the sweep
- out_csum  out  1  marks the checksum word (constant 0 without DUMP_CHECKSUM_EN)

## Operation
- States are IDLE, FETCH, SEND, CSUM, and DONE.
- IDLE:
  - busy=0, out_valid=0, sr_sel=0.
  - If start=1: idx←0, csum←0, and the next state is FETCH.
- FETCH:
  - sr_sel=idx.
  - data_q←rd_data and csum←csum ^ rd_data are captured in this cycle.
  - The next state is SEND.
- SEND:
  - out_valid=1, out_data=data_q, out_idx=idx.
  - out_last=1 only when idx==NUM_REGS-1 and the checksum is disabled.
  - sr_sel holds idx.
  - On handshake with idx<NUM_REGS-1: idx←idx+1, and the next state is FETCH.
  - On handshake with idx==NUM_REGS-1: the next state is CSUM if enabled, else DONE.
  - Without handshake, the state stays SEND and all outputs hold stable.
- CSUM (DUMP_CHECKSUM_EN only):
  - out_valid=1, out_data=csum, out_idx=NUM_REGS-1, out_csum=1, out_last=1.
  - Holds until handshake, then goes to DONE.
- DONE: done=1 for exactly this cycle, busy=1, out_valid=0, then IDLE.
- Snapshot rule:
  - Each word is the register value at its own FETCH cycle.
  - Writes to a register after its FETCH cycle are not reflected, and are not included in the checksum.
- abort=1 in any non-IDLE state:
  - The next state is IDLE, with no done pulse.
  - abort has priority over a same-cycle handshake: the word counts as accepted downstream, but the sweep ends.
- start while busy is ignored.
- start and abort together in IDLE: abort wins and the state stays IDLE.
- The index counter never wraps; the sweep ends after NUM_REGS words.

## Timing
- Reset values:
  - state=IDLE, idx=0, csum=0, data_q=0.
  - busy=0, done=0, out_valid=0, out_last=0, out_csum=0.
  - sr_sel=0, out_data=0, out_idx=0.
- start at cycle t gives FETCH at t+1 and the first out_valid at t+2.
- Each word takes at least 2 cycles (FETCH + SEND), so with out_ready held high:
  - Without checksum: last handshake at t+2·NUM_REGS, done pulse at t+2·NUM_REGS+1, busy falls at t+2·NUM_REGS+2.
  - With checksum: the checksum word is valid at t+2·NUM_REGS+1 and accepted that cycle, done pulse at t+2·NUM_REGS+2.
- Registered outputs: out_data, out_idx, out_valid, out_last, out_csum, busy, done.
- sr_sel is a direct decode of idx.
- Reset mid-sweep: all outputs take reset values on the next edge, with no partial done.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - The CSUM state exists.
  - After R(NUM_REGS-1), a ninth word is emitted: the XOR of all captured words, with out_csum=1 and out_last=1.
- DUMP_CHECKSUM_EN undefined:
  - No CSUM state and no csum register.
  - out_csum is tied 0.
  - out_last is on R(NUM_REGS-1).

## Test plan
- Basic sweep, checksum off, registers preloaded R0..R7 = 0x1111·(i+1) (0x1111..0x8888), out_ready=1, start pulse:
  - 8 words, out_idx 0..7, first valid 2 cycles after start.
  - out_last only on 0x8888.
  - done one cycle after that handshake.
- Backpressure:
  - out_ready toggles 0,0,1 repeatedly.
  - out_data, out_idx, and out_last hold stable while valid && !ready.
  - No word is lost or duplicated, and the total is 8 words.
- Checksum on, same preload:
  - Ninth word = 0x1111^0x2222^…^0x8888 = 0x8888, with out_csum=1 and out_last=1.
  - R7 is not marked last.
- Snapshot:
  - Write R5←0xBEEF after R5's FETCH and before its handshake: the word still shows 0x6666.
  - Write R6←0xCAFE before R6's FETCH: the word shows 0xCAFE.
- Abort:
  - abort during the SEND of R3 with out_ready=1: next cycle IDLE, busy=0, no done.
  - A following start restarts at R0.
- Reset and start-while-busy:
  - start pulses while busy have no effect.
  - reset asserted during R2's SEND: all outputs at reset values the next cycle.
